// File: rtl/regfile_pkg.sv
// regfile_pkg: shared context-sequencer state and operation encodings
package regfile_pkg;
  typedef enum logic [1:0] {CTX_IDLE, CTX_SAVE, CTX_RESTORE, CTX_DONE} ctx_state_t;
  typedef enum logic {CTX_OP_SAVE, CTX_OP_RESTORE} ctx_op_t;
endpackage

// File: rtl/regfile_ctx_sequencer.sv
// regfile_ctx_sequencer: walks k over the bank one register per cycle for context save/restore
module regfile_ctx_sequencer
  import regfile_pkg::*;
#(
  parameter int NREGS = 6,
  parameter int SELW  = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ctx_req,
  input  logic            ctx_op,
  output logic            copy_en,
  output ctx_op_t         copy_dir,
  output logic [SELW-1:0] copy_idx,
  output logic            ctx_busy,
  output logic            ctx_done
);
  ctx_state_t      state_q;
  logic [SELW-1:0] k_q;
  // Requests are only taken from idle; the last copy leads to a single done cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CTX_IDLE;
      k_q     <= '0;
    end else begin
      case (state_q)
        CTX_IDLE: if (ctx_req) begin
          state_q <= ctx_op ? CTX_RESTORE : CTX_SAVE;
          k_q     <= '0;
        end
        CTX_SAVE, CTX_RESTORE: begin
          k_q <= k_q + 1'b1;
          if (k_q == SELW'(NREGS - 1)) state_q <= CTX_DONE;
        end
        default: state_q <= CTX_IDLE;
      endcase
    end
  end
  assign ctx_busy = (state_q == CTX_SAVE) || (state_q == CTX_RESTORE);
  assign ctx_done = state_q == CTX_DONE;
  assign copy_en  = ctx_busy;
  assign copy_dir = (state_q == CTX_RESTORE) ? CTX_OP_RESTORE : CTX_OP_SAVE;
  assign copy_idx = k_q;
endmodule

// File: rtl/banked_register_file.sv
// banked_register_file: multi-port register file with write bypass and a shadow bank for context save/restore
module banked_register_file
  import regfile_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NREGS     = 6,
  parameter int NREAD     = 2,
  parameter int BYPASS    = 1,
  parameter int ALU_A_IDX = 1,
  parameter int ALU_B_IDX = 2,
  parameter int ALU_R_IDX = 3,
  localparam int SELW     = $clog2(NREGS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   save,
  input  logic [SELW-1:0]        saveselector,
  input  logic [WIDTH-1:0]       savebus,
  input  logic [NREAD*SELW-1:0]  loadselector,
  output logic [NREAD*WIDTH-1:0] loadbus,
  output logic [WIDTH-1:0]       aluoperandA,
  output logic [WIDTH-1:0]       aluoperandB,
  output logic [WIDTH-1:0]       aluresult,
  input  logic                   ctx_req,
  input  logic                   ctx_op,
  output logic                   ctx_busy,
  output logic                   ctx_done,
  output logic                   save_err
);
  logic [WIDTH-1:0] regs_q   [NREGS];
  logic [WIDTH-1:0] shadow_q [NREGS];
  logic             save_err_q;
  logic             copy_en;
  ctx_op_t          copy_dir;
  logic [SELW-1:0]  copy_idx;
  logic             wr_ok;
  regfile_ctx_sequencer #(.NREGS(NREGS), .SELW(SELW)) u_seq (
    .clock    (clock),
    .reset    (reset),
    .ctx_req  (ctx_req),
    .ctx_op   (ctx_op),
    .copy_en  (copy_en),
    .copy_dir (copy_dir),
    .copy_idx (copy_idx),
    .ctx_busy (ctx_busy),
    .ctx_done (ctx_done)
  );
  assign wr_ok = save && !ctx_busy && !ctx_done && (32'(saveselector) < NREGS);
  // Architectural writes, sequencer copies in either direction, and the refused-write pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      regs_q     <= '{default: '0};
      shadow_q   <= '{default: '0};
      save_err_q <= 1'b0;
    end else begin
      save_err_q <= save && !wr_ok;
      if (wr_ok) regs_q[saveselector] <= savebus;
      if (copy_en && copy_dir == CTX_OP_SAVE) shadow_q[copy_idx] <= regs_q[copy_idx];
      if (copy_en && copy_dir == CTX_OP_RESTORE) regs_q[copy_idx] <= shadow_q[copy_idx];
    end
  end
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [SELW-1:0] idx;
    assign idx = loadselector[i*SELW +: SELW];
    assign loadbus[i*WIDTH +: WIDTH] = (BYPASS != 0 && wr_ok && idx == saveselector) ? savebus :
                                       (32'(idx) < NREGS) ? regs_q[idx] : '0;
  end
  assign aluoperandA = regs_q[ALU_A_IDX];
  assign aluoperandB = regs_q[ALU_B_IDX];
  assign aluresult   = regs_q[ALU_R_IDX];
  assign save_err    = save_err_q;
endmodule

// File: tb/tb_banked_register_file.sv
// tb_banked_register_file: randomized self-checking bench against a whole-bank reference model
module tb_banked_register_file;
  logic        clock = 0;
  logic        reset = 1;
  logic        save = 0;
  logic [2:0]  saveselector = '0;
  logic [7:0]  savebus = '0;
  logic [5:0]  loadselector = '0;
  logic [15:0] loadbus;
  logic [7:0]  alu_a, alu_b, alu_r;
  logic        ctx_req = 0, ctx_op = 0;
  logic        ctx_busy, ctx_done, save_err;
  logic        b_reset = 1, b_save = 0;
  logic [3:0]  b_sel = '0;
  logic [31:0] b_bus = '0;
  logic [7:0]  b_ls = '0;
  logic [63:0] b_lb;
  logic [31:0] b_a, b_b, b_r;
  logic        b_req = 0, b_op = 0;
  logic        b_busy, b_done, b_err;
  logic [7:0]  m_regs [6];
  logic [7:0]  m_shadow [6];
  logic [31:0] mb_regs [16];
  logic [31:0] mb_shadow [16];
  int          errors = 0;
  int          checks = 0;

  banked_register_file dut (
    .clock(clock), .reset(reset), .save(save), .saveselector(saveselector), .savebus(savebus),
    .loadselector(loadselector), .loadbus(loadbus), .aluoperandA(alu_a), .aluoperandB(alu_b),
    .aluresult(alu_r), .ctx_req(ctx_req), .ctx_op(ctx_op), .ctx_busy(ctx_busy),
    .ctx_done(ctx_done), .save_err(save_err)
  );

  banked_register_file #(.WIDTH(32), .NREGS(16)) dut_big (
    .clock(clock), .reset(b_reset), .save(b_save), .saveselector(b_sel), .savebus(b_bus),
    .loadselector(b_ls), .loadbus(b_lb), .aluoperandA(b_a), .aluoperandB(b_b),
    .aluresult(b_r), .ctx_req(b_req), .ctx_op(b_op), .ctx_busy(b_busy),
    .ctx_done(b_done), .save_err(b_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int sel, input logic [7:0] d);
    save = 1; saveselector = 3'(sel); savebus = d;
    tick();
    save = 0;
    if (sel < 6) m_regs[sel] = d;
  endtask

  task automatic check_all(input string tag);
    for (int r = 0; r < 6; r++) begin
      loadselector = {3'(5 - r), 3'(r)};
      #1;
      checks++;
      if (loadbus[7:0] !== m_regs[r]) begin
        errors++; $display("FAIL %s rd0 r%0d got %h exp %h", tag, r, loadbus[7:0], m_regs[r]);
      end
      checks++;
      if (loadbus[15:8] !== m_regs[5-r]) begin
        errors++; $display("FAIL %s rd1 r%0d got %h exp %h", tag, 5 - r, loadbus[15:8], m_regs[5-r]);
      end
    end
    checks++;
    if ({alu_a, alu_b, alu_r} !== {m_regs[1], m_regs[2], m_regs[3]}) begin
      errors++; $display("FAIL %s alu taps got %h %h %h exp %h %h %h", tag, alu_a, alu_b, alu_r, m_regs[1], m_regs[2], m_regs[3]);
    end
  endtask

  task automatic run_ctx(input bit op, output int busy_n, output int done_n);
    ctx_req = 1; ctx_op = op;
    tick();
    ctx_req = 0;
    busy_n = 0;
    while (ctx_busy === 1'b1 && busy_n < 40) begin
      busy_n++;
      tick();
    end
    done_n = 0;
    for (int c = 0; c < 3; c++) begin
      if (ctx_done === 1'b1) done_n++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1;
    tick(); tick();
    reset = 0;
    foreach (m_regs[r]) begin m_regs[r] = '0; m_shadow[r] = '0; end
    checks++;
    if ({ctx_busy, ctx_done, save_err} !== 3'b000) begin
      errors++; $display("FAIL reset flags got %b exp 000", {ctx_busy, ctx_done, save_err});
    end
    check_all("reset");
  endtask

  task automatic test_rw();
    int sel;
    logic [7:0] d;
    wr(4, 8'hA5); wr(5, 8'h3C);
    loadselector = {3'd5, 3'd4};
    #1;
    checks++;
    if (loadbus !== 16'h3CA5) begin
      errors++; $display("FAIL rw r4/r5 got %h exp 3ca5", loadbus);
    end
    for (int n = 0; n < 24; n++) begin
      sel = $urandom_range(0, 7);
      d = 8'($urandom);
      wr(sel, d);
      checks++;
      if (save_err !== (sel >= 6)) begin
        errors++; $display("FAIL rw save_err sel=%0d got %b exp %b", sel, save_err, sel >= 6);
      end
    end
    check_all("rw random");
    reset = 1;
    tick();
    reset = 0;
    foreach (m_regs[r]) begin m_regs[r] = '0; m_shadow[r] = '0; end
    check_all("rw after reset");
  endtask

  task automatic test_bypass();
    save = 1; saveselector = 3'd2; savebus = 8'h77; loadselector = {3'd0, 3'd2};
    #1;
    checks++;
    if (loadbus[7:0] !== 8'h77) begin
      errors++; $display("FAIL bypass rd got %h exp 77", loadbus[7:0]);
    end
    checks++;
    if (alu_b !== m_regs[2]) begin
      errors++; $display("FAIL bypass aluB early got %h exp %h", alu_b, m_regs[2]);
    end
    @(posedge clock); #1;
    save = 0;
    m_regs[2] = 8'h77;
    checks++;
    if (alu_b !== 8'h77) begin
      errors++; $display("FAIL bypass aluB late got %h exp 77", alu_b);
    end
  endtask

  task automatic test_round_trip();
    int bn, dn;
    for (int r = 0; r < 6; r++) wr(r, 8'(r + 1));
    run_ctx(0, bn, dn);
    m_shadow = m_regs;
    checks++;
    if (bn != 6 || dn != 1) begin
      errors++; $display("FAIL trip save busy=%0d done=%0d exp 6 1", bn, dn);
    end
    for (int r = 0; r < 6; r++) wr(r, 8'hFF);
    check_all("trip overwrite");
    run_ctx(1, bn, dn);
    m_regs = m_shadow;
    checks++;
    if (bn != 6 || dn != 1) begin
      errors++; $display("FAIL trip restore busy=%0d done=%0d exp 6 1", bn, dn);
    end
    check_all("trip restore");
  endtask

  task automatic test_collision();
    int dn;
    ctx_req = 1; ctx_op = 0;
    tick();
    save = 1; saveselector = 3'd1; savebus = 8'h5A;
    tick();
    save = 0; ctx_req = 0;
    checks++;
    if (save_err !== 1'b1) begin
      errors++; $display("FAIL collide save_err got %b exp 1", save_err);
    end
    tick();
    checks++;
    if (save_err !== 1'b0) begin
      errors++; $display("FAIL collide save_err pulse got %b exp 0", save_err);
    end
    dn = 0;
    for (int c = 0; c < 12; c++) begin
      if (ctx_done === 1'b1) dn++;
      tick();
    end
    m_shadow = m_regs;
    checks++;
    if (dn != 1 || ctx_busy !== 1'b0) begin
      errors++; $display("FAIL collide done=%0d busy=%b exp 1 0", dn, ctx_busy);
    end
    check_all("collide");
  endtask

  task automatic test_boundary();
    int bn, dn;
    wr(7, 8'hEE);
    checks++;
    if (save_err !== 1'b1) begin
      errors++; $display("FAIL bound sel7 save_err got %b exp 1", save_err);
    end
    check_all("bound sel7");
    loadselector = {3'd7, 3'd6};
    #1;
    checks++;
    if (loadbus !== 16'h0000) begin
      errors++; $display("FAIL bound read6/7 got %h exp 0000", loadbus);
    end
    save = 1; saveselector = 3'd3; savebus = 8'h42; ctx_req = 1; ctx_op = 0;
    tick();
    save = 0; ctx_req = 0;
    m_regs[3] = 8'h42;
    bn = 0;
    while (ctx_busy === 1'b1 && bn < 40) begin bn++; tick(); end
    tick(); tick();
    m_shadow = m_regs;
    checks++;
    if (bn != 6) begin
      errors++; $display("FAIL bound same-cycle busy=%0d exp 6", bn);
    end
    wr(3, 8'h00);
    run_ctx(1, bn, dn);
    m_regs = m_shadow;
    check_all("bound shadow3");
  endtask

  task automatic test_reset_mid_restore();
    int bn, dn;
    ctx_req = 1; ctx_op = 1;
    tick();
    ctx_req = 0;
    tick(); tick(); tick();
    reset = 1;
    tick();
    reset = 0;
    foreach (m_regs[r]) begin m_regs[r] = '0; m_shadow[r] = '0; end
    checks++;
    if (ctx_busy !== 1'b0 || ctx_done !== 1'b0) begin
      errors++; $display("FAIL midrst busy=%b done=%b exp 0 0", ctx_busy, ctx_done);
    end
    check_all("midrst regs");
    for (int r = 0; r < 6; r++) wr(r, 8'(8'h11 * (r + 1)));
    run_ctx(1, bn, dn);
    m_regs = m_shadow;
    checks++;
    if (bn != 6 || dn != 1) begin
      errors++; $display("FAIL midrst restore busy=%0d done=%0d exp 6 1", bn, dn);
    end
    check_all("midrst shadow");
  endtask

  task automatic b_check(input string tag);
    for (int r = 0; r < 16; r++) begin
      b_ls = {4'(15 - r), 4'(r)};
      #1;
      checks++;
      if (b_lb !== {mb_regs[15-r], mb_regs[r]}) begin
        errors++; $display("FAIL %s big r%0d got %h exp %h", tag, r, b_lb, {mb_regs[15-r], mb_regs[r]});
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic b_ctx(input bit op, output int bn);
    b_req = 1; b_op = op;
    tick();
    b_req = 0;
    bn = 0;
    while (b_busy === 1'b1 && bn < 80) begin bn++; tick(); end
    checks++;
    if (b_done !== 1'b1) begin
      errors++; $display("FAIL big done got %b exp 1", b_done);
    end
    tick();
  endtask

  task automatic test_big();
    int bn;
    b_reset = 1;
    tick();
    b_reset = 0;
    for (int r = 0; r < 16; r++) begin
      mb_regs[r] = $urandom;
      b_save = 1; b_sel = 4'(r); b_bus = mb_regs[r];
      tick();
    end
    b_save = 0;
    b_ctx(0, bn);
    mb_shadow = mb_regs;
    checks++;
    if (bn != 16) begin
      errors++; $display("FAIL big save busy=%0d exp 16", bn);
    end
    for (int r = 0; r < 16; r++) begin
      mb_regs[r] = 32'hFFFF_FFFF;
      b_save = 1; b_sel = 4'(r); b_bus = 32'hFFFF_FFFF;
      tick();
    end
    b_save = 0;
    b_check("big overwrite");
    b_ctx(1, bn);
    mb_regs = mb_shadow;
    checks++;
    if (bn != 16) begin
      errors++; $display("FAIL big restore busy=%0d exp 16", bn);
    end
    b_check("big restore");
  endtask

  // Scenario sequence followed by the single summary line
  initial begin
    test_reset();
    test_rw();
    test_bypass();
    test_round_trip();
    test_collision();
    test_boundary();
    test_reset_mid_restore();
    test_big();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
